// File: rtl/pipe_adder_sub.sv
// pipe_adder_sub: pipelined adder/subtractor. The carry chain is split into
// STAGES chunks of CW = WIDTH/STAGES bits, and each chunk is computed in its own
// register stage. A valid/ready handshake stalls the whole pipeline when the
// consumer applies backpressure.
//
// Ports:
//   clk, rst             clock (rising edge); synchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = ~stall)
//   a, b, cin, sub       operands; sub=1 computes a-b (cin is ignored)
//   out_valid/out_ready  result handshake
//   sum, cout, ovf       result modulo 2^WIDTH, carry out of MSB, signed overflow
module pipe_adder_sub #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned CW = WIDTH / STAGES;

  // Per-stage state: valid, operand a, effective operand b', partial sum
  // (chunks 0..k completed), and the carry out of chunk k.
  logic             v_q [STAGES];
  logic             v_d [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] a_d [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] b_d [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic [WIDTH-1:0] s_d [STAGES];
  logic             c_q [STAGES];
  logic             c_d [STAGES];

  // Inputs seen by each stage: ports for stage 0, previous register otherwise.
  logic             pv  [STAGES];
  logic [WIDTH-1:0] pa  [STAGES];
  logic [WIDTH-1:0] pb  [STAGES];
  logic [WIDTH-1:0] ps  [STAGES];
  logic             pc  [STAGES];

  logic stall;

  always_comb begin
    stall    = v_q[STAGES-1] & ~out_ready;
    in_ready = ~stall;
  end

  always_comb begin
    pv[0] = in_valid;
    pa[0] = a;
    pb[0] = sub ? ~b : b;
    ps[0] = '0;
    pc[0] = sub ? 1'b1 : cin;
    for (int unsigned k = 1; k < STAGES; k++) begin
      pv[k] = v_q[k-1];
      pa[k] = a_q[k-1];
      pb[k] = b_q[k-1];
      ps[k] = s_q[k-1];
      pc[k] = c_q[k-1];
    end
  end

  always_comb begin
    logic [CW:0] chunk;
    chunk = '0;
    for (int unsigned k = 0; k < STAGES; k++) begin
      chunk = {1'b0, pa[k][k*CW +: CW]} + {1'b0, pb[k][k*CW +: CW]}
            + {{CW{1'b0}}, pc[k]};
      v_d[k]            = pv[k];
      a_d[k]            = pa[k];
      b_d[k]            = pb[k];
      s_d[k]            = ps[k];
      s_d[k][k*CW +: CW] = chunk[CW-1:0];
      c_d[k]            = chunk[CW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q <= '{default: '0};
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
      c_q <= '{default: '0};
    end else if (!stall) begin
      v_q <= v_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      c_q <= c_d;
    end
  end

  // The operand MSBs ride to the last stage so ovf is derived from registered
  // state; it is therefore zero after reset and stable during a stall.
  always_comb begin
    out_valid = v_q[STAGES-1];
    sum       = s_q[STAGES-1];
    cout      = c_q[STAGES-1];
    ovf       = (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                (s_q[STAGES-1][WIDTH-1] != a_q[STAGES-1][WIDTH-1]);
  end

endmodule
